wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback (result mux output, RD, RegWrite) and a multi-cycle MUL/DIV unit that returns results out of band over a valid/ready handshake. The block tracks outstanding MUL/DIV destinations in a 32-entry pending scoreboard and raises a hazard stall toward decode. It raises a starvation stall when the pipeline monopolises the write port. It sits between the writeback stage and the register file, beside the hazard unit.

Parameters:
DATA_W, 32, register data width
REG_AW, 5, register address width (2**REG_AW architectural registers)
STARVE_LIMIT, 4, cycles a held MUL/DIV result may wait before stall_req asserts (min 1)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous active-low reset
pipe_we  in  1  writeback RegWrite
pipe_rd  in  REG_AW  writeback destination
pipe_wd  in  DATA_W  writeback result
md_issue  in  1  decode issues a MUL/DIV this cycle
md_issue_rd  in  REG_AW  destination of the issued MUL/DIV
md_valid  in  1  MUL/DIV result available
md_rd  in  REG_AW  MUL/DIV result destination
md_wd  in  DATA_W  MUL/DIV result data
md_ready  out  1  arbiter accepts MUL/DIV result
dec_rs1, dec_rs2, dec_rd  in  REG_AW  decode-stage operands
hazard_stall  out  1  decode must stall: operand or destination pending
stall_req  out  1  request to hazard unit to inject a writeback bubble
rf_we  out  1  register-file write enable
rf_rd  out  REG_AW  register-file write address
rf_wd  out  DATA_W  register-file write data

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-low. While rst=0: state=IDLE, pending=0, wait counter=0, hold register=0, rf_we=0, rf_rd=0, rf_wd=0, stall_req=0. md_ready=1 because it is derived from IDLE. hazard_stall=0 because pending=0.
- Reset mid-operation drops any held MUL/DIV result and clears all pending bits. The MUL/DIV unit is reset by the same rst.
- rf_* outputs are registered, with 1-cycle latency from the winning source.
- A write with rd=0 never asserts rf_we.
- Pipe write is "active" when pipe_we=1 and pipe_rd!=0. An active pipe write always wins the port and commits on the next edge: rf_we=1, rf_rd=pipe_rd, rf_wd=pipe_wd.
- md_ready = (state==IDLE). A handshake occurs when md_valid and md_ready are both 1.
- FSM states: IDLE, HOLD, STARVE.
  - IDLE, handshake, no active pipe write: commit the MUL/DIV result directly next edge; stay in IDLE.
  - IDLE, handshake, active pipe write: capture md_rd/md_wd into the hold register; counter=1; go to HOLD.
  - HOLD, no active pipe write: commit the hold register; go to IDLE.
  - HOLD, active pipe write: counter+1; when counter reaches STARVE_LIMIT, go to STARVE.
  - STARVE: stall_req=1, registered and asserted the cycle after entry. Remain until a cycle with no active pipe write; then commit the hold register, deassert stall_req, go to IDLE.
- Pending scoreboard:
  - md_issue with md_issue_rd!=0 sets pending[md_issue_rd].
  - A MUL/DIV commit (the edge where rf_we is loaded from the MUL/DIV source) clears pending[rd].
  - If set and clear hit the same index on the same edge, set wins.
  - Issue with rd=0 is ignored.
- hazard_stall is combinational: (rs1!=0 and pending[rs1]) or (rs2!=0 and pending[rs2]) or (rd!=0 and pending[rd]). The rd term covers WAW. It evaluates the registered pending vector, so a clear is visible one cycle after commit.
- A pipe write to a pending register is a decode bug. Decode is prevented from this by hazard_stall. Verification asserts it never happens.
- At most one MUL/DIV result is outstanding in the arbiter. The counter saturates at STARVE_LIMIT.

Decomposition:
- Shared package (core_pkg): REG_AW, DATA_W, the arbiter state enum (IDLE/HOLD/STARVE), and the constant for register x0.
- One natural sub-module: wb_scoreboard. It holds the pending bitmap with set/clear and set-wins priority, and provides the three-operand combinational lookup.
- The FSM, hold register, counter, and output registers stay in wb_port_arbiter.

Test Plan:
- Reset check: release rst with all inputs 0. Required: rf_we=0, md_ready=1, stall_req=0, hazard_stall=0. Then pipe_we=1, pipe_rd=5, pipe_wd=0xDEADBEEF for one cycle. Required: next cycle rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF.
- Direct MUL/DIV commit: md_issue rd=7, then md_valid rd=7, wd=0x12 with pipe idle. Required: rf_we=1, rf_rd=7, rf_wd=0x12 the next cycle; hazard_stall for dec_rs1=7 is 1 before the commit and 0 one cycle after it.
- Collision: md_valid rd=9, wd=0x55 in the same cycle as pipe write rd=3, wd=0xAA. Required: rf_rd=3, rf_wd=0xAA first; md_ready=0; rf_rd=9, rf_wd=0x55 on the following idle cycle.
- Starvation: with STARVE_LIMIT=4, hold a MUL/DIV result and drive continuous active pipe writes. Required: stall_req=1 after 4 blocked cycles. On the first bubble, the held result commits and stall_req=0 the next cycle.
- x0 and set-wins: md_issue rd=0 leaves pending unchanged and pipe write rd=0 gives rf_we=0. Then issue rd=12 on the same edge as the MUL/DIV commit to rd=12. Required: pending[12] stays 1.
- Async reset in HOLD: assert rst mid-cycle. Required: rf_we=0, pending=0, state=IDLE immediately, with no commit of the held value after release.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the writeback port arbiter slice.
package wb_port_arbiter_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef logic [REG_AW-1:0] regAddr_t;
  typedef logic [DATA_W-1:0] regData_t;

  // Register x0 is hardwired to zero, so writes to it are discarded.
  localparam regAddr_t REG_X0 = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    STARVE = 2'd2
  } arbState_e;

  // True when a destination names a real, writable register.
  function automatic logic isWritable(input regAddr_t rd);
    return rd != REG_X0;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the writeback, MUL/DIV, decode and register-file signals
// around the arbiter. The master side drives pipeline/decode/MUL-DIV
// inputs; the slave side is the arbiter itself.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic     pipe_we;
  regAddr_t pipe_rd;
  regData_t pipe_wd;

  logic     md_issue;
  regAddr_t md_issue_rd;
  logic     md_valid;
  regAddr_t md_rd;
  regData_t md_wd;
  logic     md_ready;

  regAddr_t dec_rs1;
  regAddr_t dec_rs2;
  regAddr_t dec_rd;
  logic     hazard_stall;
  logic     stall_req;

  logic     rf_we;
  regAddr_t rf_rd;
  regData_t rf_wd;

  modport master (
    output pipe_we, pipe_rd, pipe_wd,
    output md_issue, md_issue_rd, md_valid, md_rd, md_wd,
    output dec_rs1, dec_rs2, dec_rd,
    input  md_ready, hazard_stall, stall_req,
    input  rf_we, rf_rd, rf_wd
  );

  modport slave (
    input  pipe_we, pipe_rd, pipe_wd,
    input  md_issue, md_issue_rd, md_valid, md_rd, md_wd,
    input  dec_rs1, dec_rs2, dec_rd,
    output md_ready, hazard_stall, stall_req,
    output rf_we, rf_rd, rf_wd
  );

endinterface

// File: rtl/wb_port_arbiter_scoreboard.sv
// Pending-destination bitmap for in-flight MUL/DIV operations, with a
// three-operand lookup that tells decode when it must wait.
module wb_port_arbiter_scoreboard
  import wb_port_arbiter_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     set_i,
  input  regAddr_t setIdx_i,
  input  logic     clr_i,
  input  regAddr_t clrIdx_i,
  input  regAddr_t rs1_i,
  input  regAddr_t rs2_i,
  input  regAddr_t rd_i,
  output logic     hazard_o
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // An operand only conflicts if it is a real register with a result in flight.
  function automatic logic isBusy(input logic [NUM_REGS-1:0] vec, input regAddr_t idx);
    return isWritable(idx) && vec[idx];
  endfunction

  // Clear first, then set, so a new issue to the same register survives
  // the commit of the previous result on the same edge.
  always_comb begin
    pending_d = pending_q;
    if (clr_i) begin
      pending_d[clrIdx_i] = 1'b0;
    end
    if (set_i && isWritable(setIdx_i)) begin
      pending_d[setIdx_i] = 1'b1;
    end
  end

  // Pending bitmap register; reset forgets every in-flight destination.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign hazard_o = isBusy(pending_q, rs1_i) || isBusy(pending_q, rs2_i) || isBusy(pending_q, rd_i);

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and an
// out-of-band MUL/DIV unit. The pipeline always wins; a blocked MUL/DIV
// result is parked in a hold register, and if the pipeline keeps the port
// busy for too long a bubble is requested from the hazard unit.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk_i,
  input logic             rst_ni,
  wb_port_arbiter_if.slave bus
);
  import wb_port_arbiter_pkg::*;

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  arbState_e        state_q, state_d;
  regAddr_t         holdRd_q, holdRd_d;
  regData_t         holdWd_q, holdWd_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic             rfWe_q, rfWe_d;
  regAddr_t         rfRd_q, rfRd_d;
  regData_t         rfWd_q, rfWd_d;
  logic             stallReq_q, stallReq_d;

  logic     pipeActive;
  logic     mdReady;
  logic     handshake;
  logic     mdCommit;
  regAddr_t mdCommitRd;
  logic     hazard;

  assign pipeActive = bus.pipe_we && isWritable(bus.pipe_rd);
  assign mdReady    = (state_q == IDLE);
  assign handshake  = bus.md_valid && mdReady;

  // Port arbitration: pipeline first, then a fresh or held MUL/DIV result.
  // A MUL/DIV result that loses the port waits in the hold register, and
  // the wait counter decides when to ask for a bubble.
  always_comb begin
    state_d    = state_q;
    holdRd_d   = holdRd_q;
    holdWd_d   = holdWd_q;
    waitCnt_d  = waitCnt_q;
    rfWe_d     = 1'b0;
    rfRd_d     = rfRd_q;
    rfWd_d     = rfWd_q;
    mdCommit   = 1'b0;
    mdCommitRd = REG_X0;

    if (pipeActive) begin
      rfWe_d = 1'b1;
      rfRd_d = bus.pipe_rd;
      rfWd_d = bus.pipe_wd;
    end

    case (state_q)
      IDLE: begin
        if (handshake) begin
          if (pipeActive) begin
            holdRd_d  = bus.md_rd;
            holdWd_d  = bus.md_wd;
            waitCnt_d = ONE_C;
            state_d   = (ONE_C >= LIMIT_C) ? STARVE : HOLD;
          end else begin
            rfWe_d     = isWritable(bus.md_rd);
            rfRd_d     = bus.md_rd;
            rfWd_d     = bus.md_wd;
            mdCommit   = 1'b1;
            mdCommitRd = bus.md_rd;
          end
        end
      end
      HOLD: begin
        if (pipeActive) begin
          waitCnt_d = (waitCnt_q < LIMIT_C) ? (waitCnt_q + ONE_C) : LIMIT_C;
          if (waitCnt_d == LIMIT_C) begin
            state_d = STARVE;
          end
        end else begin
          rfWe_d     = isWritable(holdRd_q);
          rfRd_d     = holdRd_q;
          rfWd_d     = holdWd_q;
          mdCommit   = 1'b1;
          mdCommitRd = holdRd_q;
          waitCnt_d  = '0;
          state_d    = IDLE;
        end
      end
      STARVE: begin
        if (!pipeActive) begin
          rfWe_d     = isWritable(holdRd_q);
          rfRd_d     = holdRd_q;
          rfWd_d     = holdWd_q;
          mdCommit   = 1'b1;
          mdCommitRd = holdRd_q;
          waitCnt_d  = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    stallReq_d = (state_d == STARVE);
  end

  // State, hold register, wait counter and registered register-file outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      holdRd_q   <= '0;
      holdWd_q   <= '0;
      waitCnt_q  <= '0;
      rfWe_q     <= 1'b0;
      rfRd_q     <= '0;
      rfWd_q     <= '0;
      stallReq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      holdRd_q   <= holdRd_d;
      holdWd_q   <= holdWd_d;
      waitCnt_q  <= waitCnt_d;
      rfWe_q     <= rfWe_d;
      rfRd_q     <= rfRd_d;
      rfWd_q     <= rfWd_d;
      stallReq_q <= stallReq_d;
    end
  end

  wb_port_arbiter_scoreboard u_scoreboard (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .set_i    (bus.md_issue),
    .setIdx_i (bus.md_issue_rd),
    .clr_i    (mdCommit),
    .clrIdx_i (mdCommitRd),
    .rs1_i    (bus.dec_rs1),
    .rs2_i    (bus.dec_rs2),
    .rd_i     (bus.dec_rd),
    .hazard_o (hazard)
  );

  assign bus.md_ready     = mdReady;
  assign bus.hazard_stall = hazard;
  assign bus.stall_req    = stallReq_q;
  assign bus.rf_we        = rfWe_q;
  assign bus.rf_rd        = rfRd_q;
  assign bus.rf_wd        = rfWd_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: every register-file write the
// bench provokes is queued when driven and matched when it appears.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int STARVE_LIMIT = 4;

  typedef struct packed {
    regAddr_t rd;
    regData_t wd;
  } wrExp_t;

  logic clk;
  logic rst_n;
  wrExp_t expQ[$];
  int checkCount = 0;
  int passCount  = 0;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveInputs(input logic pWe, input regAddr_t pRd, input regData_t pWd,
                             input logic mIss, input regAddr_t mIssRd,
                             input logic mVal, input regAddr_t mRd, input regData_t mWd);
    bus.pipe_we     = pWe;
    bus.pipe_rd     = pRd;
    bus.pipe_wd     = pWd;
    bus.md_issue    = mIss;
    bus.md_issue_rd = mIssRd;
    bus.md_valid    = mVal;
    bus.md_rd       = mRd;
    bus.md_wd       = mWd;
  endtask

  task automatic applyStimulus(input logic pWe, input regAddr_t pRd, input regData_t pWd,
                               input logic mIss, input regAddr_t mIssRd,
                               input logic mVal, input regAddr_t mRd, input regData_t mWd);
    driveInputs(pWe, pRd, pWd, mIss, mIssRd, mVal, mRd, mWd);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic expectWrite(input regAddr_t rd, input regData_t wd);
    wrExp_t e;
    e.rd = rd;
    e.wd = wd;
    expQ.push_back(e);
  endtask

  task automatic setDecode(input regAddr_t rs1, input regAddr_t rs2, input regAddr_t rd);
    bus.dec_rs1 = rs1;
    bus.dec_rs2 = rs2;
    bus.dec_rd  = rd;
    #1;
  endtask

  task automatic checkWrite(input string tag, input regAddr_t rd, input regData_t wd);
    checkOutput({tag, "_we"}, 32'(bus.rf_we), 32'd1);
    checkOutput({tag, "_rd"}, 32'(bus.rf_rd), 32'(rd));
    checkOutput({tag, "_wd"}, bus.rf_wd, wd);
  endtask

  // Scoreboard side: every write seen on the register file must match
  // the oldest queued expectation.
  always @(negedge clk) begin
    wrExp_t got;
    if (rst_n && bus.rf_we) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write", 32'(bus.rf_we), 32'd0);
      end else begin
        got = expQ.pop_front();
        checkOutput("sb_rd", 32'(bus.rf_rd), 32'(got.rd));
        checkOutput("sb_wd", bus.rf_wd, got.wd);
      end
    end
  end

  // Run-time bound in case the design or bench stalls.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    driveInputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    bus.dec_rs1 = 5'd0;
    bus.dec_rs2 = 5'd0;
    bus.dec_rd  = 5'd0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    idleCycle();

    $display("[TB] reset state");
    checkOutput("rst_rf_we", 32'(bus.rf_we), 32'd0);
    checkOutput("rst_md_ready", 32'(bus.md_ready), 32'd1);
    checkOutput("rst_stall_req", 32'(bus.stall_req), 32'd0);
    checkOutput("rst_pending", dut.u_scoreboard.pending_q, 32'h0);
    setDecode(5'd1, 5'd2, 5'd3);
    checkOutput("rst_hazard", 32'(bus.hazard_stall), 32'd0);
    setDecode(5'd0, 5'd0, 5'd0);

    $display("[TB] pipeline write");
    expectWrite(5'd5, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    checkWrite("pipe", 5'd5, 32'hDEAD_BEEF);
    idleCycle();
    checkOutput("pipe_idle_we", 32'(bus.rf_we), 32'd0);

    $display("[TB] direct MUL/DIV commit");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
    setDecode(5'd7, 5'd0, 5'd0);
    checkOutput("raw_hazard_rs1", 32'(bus.hazard_stall), 32'd1);
    setDecode(5'd0, 5'd0, 5'd7);
    checkOutput("waw_hazard_rd", 32'(bus.hazard_stall), 32'd1);
    setDecode(5'd7, 5'd0, 5'd0);
    checkOutput("md_ready_idle", 32'(bus.md_ready), 32'd1);
    expectWrite(5'd7, 32'h12);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h12);
    checkWrite("md_direct", 5'd7, 32'h12);
    checkOutput("hazard_cleared_rs1", 32'(bus.hazard_stall), 32'd0);
    setDecode(5'd0, 5'd0, 5'd0);

    $display("[TB] collision");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0);
    expectWrite(5'd3, 32'hAA);
    expectWrite(5'd9, 32'h55);
    applyStimulus(1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, 1'b1, 5'd9, 32'h55);
    checkWrite("coll_pipe", 5'd3, 32'hAA);
    checkOutput("coll_md_ready", 32'(bus.md_ready), 32'd0);
    idleCycle();
    checkWrite("coll_held", 5'd9, 32'h55);
    checkOutput("coll_md_ready_back", 32'(bus.md_ready), 32'd1);
    checkOutput("coll_stall_req", 32'(bus.stall_req), 32'd0);
    setDecode(5'd0, 5'd9, 5'd0);
    checkOutput("coll_hazard_rs2", 32'(bus.hazard_stall), 32'd0);
    setDecode(5'd0, 5'd0, 5'd0);

    $display("[TB] starvation");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 1'b0, 5'd0, 32'h0);
    expectWrite(5'd1, 32'd100);
    applyStimulus(1'b1, 5'd1, 32'd100, 1'b0, 5'd0, 1'b1, 5'd20, 32'hCAFE);
    checkOutput("starve_first_stall", 32'(bus.stall_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      expectWrite(5'(2 + i), 32'(101 + i));
      applyStimulus(1'b1, 5'(2 + i), 32'(101 + i), 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
      checkOutput("starve_stall_req", 32'(bus.stall_req), 32'((i + 2) >= STARVE_LIMIT));
      checkOutput("starve_md_ready", 32'(bus.md_ready), 32'd0);
    end
    expectWrite(5'd20, 32'hCAFE);
    idleCycle();
    checkWrite("starve_commit", 5'd20, 32'hCAFE);
    checkOutput("starve_stall_drop", 32'(bus.stall_req), 32'd0);
    checkOutput("starve_md_ready_back", 32'(bus.md_ready), 32'd1);

    $display("[TB] x0 and set-wins");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0);
    checkOutput("x0_issue_pending", dut.u_scoreboard.pending_q, 32'h0);
    applyStimulus(1'b1, 5'd0, 32'h5A5A, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    checkOutput("x0_pipe_we", 32'(bus.rf_we), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b0, 5'd0, 32'h0);
    checkOutput("issue12_pending", dut.u_scoreboard.pending_q, 32'h0000_1000);
    expectWrite(5'd12, 32'h77);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b1, 5'd12, 32'h77);
    checkWrite("setwin_commit", 5'd12, 32'h77);
    checkOutput("setwin_pending", dut.u_scoreboard.pending_q, 32'h0000_1000);
    setDecode(5'd12, 5'd0, 5'd0);
    checkOutput("setwin_hazard", 32'(bus.hazard_stall), 32'd1);
    expectWrite(5'd12, 32'h78);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd12, 32'h78);
    checkOutput("setwin_cleared", dut.u_scoreboard.pending_q, 32'h0);
    setDecode(5'd0, 5'd0, 5'd0);

    $display("[TB] async reset while holding");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 1'b0, 5'd0, 32'h0);
    expectWrite(5'd6, 32'h66);
    applyStimulus(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 1'b1, 5'd15, 32'h99);
    checkOutput("hold_md_ready", 32'(bus.md_ready), 32'd0);
    driveInputs(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    setDecode(5'd15, 5'd0, 5'd0);
    checkOutput("arst_rf_we", 32'(bus.rf_we), 32'd0);
    checkOutput("arst_md_ready", 32'(bus.md_ready), 32'd1);
    checkOutput("arst_stall_req", 32'(bus.stall_req), 32'd0);
    checkOutput("arst_pending", dut.u_scoreboard.pending_q, 32'h0);
    checkOutput("arst_hazard", 32'(bus.hazard_stall), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput("arst_no_commit", 32'(bus.rf_we), 32'd0);
    end
    setDecode(5'd0, 5'd0, 5'd0);

    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
